// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: A - B computed LSB first as A + ~B + 1 through one full-adder slice.
// Latency: start accepted at edge k, results and a one-cycle done pulse appear after edge k+WIDTH.
// Backpressure: none queued; start is only sampled while idle and is ignored while busy.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             carry;

  logic             nb;
  logic             sum_bit;
  logic             carry_nxt;
  logic             last_bit;
  logic [WIDTH-1:0] sr_nxt;

  // Full-adder slice on the current operand LSBs; subtrahend is inverted here.
  assign nb        = ~sb[0];
  assign sum_bit   = sa[0] ^ nb ^ carry;
  assign carry_nxt = (sa[0] & nb) | (sa[0] & carry) | (nb & carry);
  assign sr_nxt    = {sum_bit, sr[WIDTH-1:1]};
  assign last_bit  = (state == RUN) && (cnt == LAST_CNT);
  assign busy      = (state == RUN);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: leave IDLE on start, return once the MSB has been processed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST_CNT) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, serial datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      Diff  <= '0;
      Bout  <= 1'b0;
      Ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          sa    <= A;
          sb    <= B;
          carry <= 1'b1;
          cnt   <= '0;
        end
      end else begin
        sa    <= sa >> 1;
        sb    <= sb >> 1;
        sr    <= sr_nxt;
        carry <= carry_nxt;
        cnt   <= cnt + 1'b1;
        if (last_bit) begin
          // At the last step sa[0]/sb[0] are the captured operand sign bits.
          Diff <= sr_nxt;
          Bout <= ~carry_nxt;
          Ovf  <= (sa[0] ^ sb[0]) & (sum_bit ^ sa[0]);
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: scoreboard of expected results, checked on each done pulse.
// Latency and busy/done timing checked by the directed sequence.
// Reset abort, ignored start and back-to-back start are exercised.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             Ovf;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
  } res_t;

  res_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .Bout  (Bout),
    .Ovf   (Ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    res_t r;
    r.diff = a - b;
    r.bout = (a < b);
    r.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (r.diff[WIDTH-1] != a[WIDTH-1]);
    return r;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      check("busy_in_done", 32'(busy), 0);
      if (sb_q.size() == 0) begin
        check("spurious_done", 32'(done), 0);
      end else begin
        res_t e;
        e = sb_q.pop_front();
        check("diff", 32'(Diff), 32'(e.diff));
        check("bout", 32'(Bout), 32'(e.bout));
        check("ovf",  32'(Ovf),  32'(e.ovf));
      end
    end
  end

  // Count edges until done is seen; exp_lat is the number of edges still to go.
  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    check(tag, 32'(lat), 32'(exp_lat));
  endtask

  // Drive one start at a negedge and hold it across the accepting edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit expect_result);
    A     = a;
    B     = b;
    start = 1'b1;
    if (expect_result) sb_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    check("busy_after_accept", 32'(busy), 1);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    issue(a, b, 1'b1);
    wait_done("latency", WIDTH);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int dones;
    logic [WIDTH-1:0] ta [5];
    logic [WIDTH-1:0] tb [5];
    ta = '{8'h05, 8'h03, 8'h80, 8'h00, 8'h7F};
    tb = '{8'h03, 8'h05, 8'h01, 8'h00, 8'hFF};

    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_diff", 32'(Diff), 0);
    check("rst_bout", 32'(Bout), 0);
    check("rst_ovf",  32'(Ovf),  0);
    rst = 1'b0;

    // Directed operand table.
    for (int i = 0; i < 5; i++) run_op(ta[i], tb[i]);

    // Ignored start during RUN, then back-to-back start in the done cycle.
    @(negedge clk);
    issue(8'h10, 8'h01, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    A     = 8'hFF;
    B     = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_ignore_start", 32'(busy), 1);
    wait_done("latency_ignored_start", WIDTH - 3);
    issue(8'h20, 8'h10, 1'b1);
    wait_done("latency_back_to_back", WIDTH);

    // Reset mid-RUN: immediate clear and no done afterwards.
    @(negedge clk);
    issue(8'h09, 8'h04, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    check("pre_abort_diff", 32'(Diff), 32'h10);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_diff", 32'(Diff), 0);
    check("abort_bout", 32'(Bout), 0);
    check("abort_ovf",  32'(Ovf),  0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("no_done_after_abort", 32'(dones), 0);
    run_op(8'h09, 8'h04);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
